// File: rtl/complete_top.sv
// LCD image generator: init/clear sequencer, 8x8 pen cursor with move/draw modes, palette and beep.
// Defining COMPLETE_SOUND_EN builds the beep generator; otherwise sound_out is tied to zero.
module complete_top #(
    parameter int          INIT_WAIT  = 120000,
    parameter int          SLEEP_WAIT = 60000,
    parameter int          CUR_SIZE   = 8,
    parameter logic [15:0] BG_COLOR   = 16'h0000,
    parameter int          BEEP_LEN   = 50000,
    parameter int          TONE_DIV   = 25,
    parameter int          H_RES      = 240,
    parameter int          V_RES      = 320
) (
    input  logic       hwclk,
    input  logic       reset,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    input  logic       mode_pb,
    input  logic       KeyEnc,
    output logic       dcx,
    output logic       wr,
    output logic [7:0] D,
    output logic [5:0] sound_out
);
    localparam logic [15:0] CS         = 16'(CUR_SIZE);
    localparam logic [15:0] COLS       = 16'(H_RES / CUR_SIZE);
    localparam logic [15:0] ROWS       = 16'(V_RES / CUR_SIZE);
    localparam logic [31:0] CLR_BYTES  = 32'(2 * H_RES * V_RES);
    localparam logic [31:0] CELL_BYTES = 32'(2 * CUR_SIZE * CUR_SIZE);
    localparam logic [1:0]  JOB_CLEAR  = 2'd0;
    localparam logic [1:0]  JOB_ERASE  = 2'd1;
    localparam logic [1:0]  JOB_DRAW   = 2'd2;

    typedef enum logic [3:0] {
        ST_WAIT_INIT, ST_SLPOUT, ST_WAIT_SLP, ST_COLMOD, ST_COLMOD_D, ST_DISPON,
        ST_CASET, ST_CASET_D, ST_RASET, ST_RASET_D, ST_RAMWR, ST_PIXEL, ST_IDLE
    } state_t;

    state_t      r_state, w_next;
    logic [5:0]  r_sync1, r_sync2, r_sync3, w_rise;
    logic [31:0] r_cnt, r_nbytes;
    logic        r_phase, r_wr, r_dcx, r_mode, r_pend_valid;
    logic [7:0]  r_d, w_byte;
    logic [1:0]  r_job, r_pend_dir, w_evt_dir, w_svc_dir;
    logic [2:0]  r_cidx;
    logic [15:0] r_col, r_row, r_new_col, r_new_row, r_xs, r_xe, r_ys, r_ye, r_color;
    logic [15:0] w_ncol, w_nrow, w_cell_col, w_cell_row, w_pal;
    logic        w_evt_valid, w_svc_valid, w_go, w_blocked, w_send, w_byte_done, w_dcx, w_last_byte;

    // Two-flop synchroniser plus a third flop for rising-edge detection
    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= {KeyEnc, mode_pb, right, left, down, up};
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end
    assign w_rise = r_sync2 & ~r_sync3;

    always_comb begin
        w_evt_valid = |w_rise[3:0];
        if (w_rise[0])      w_evt_dir = 2'd0;
        else if (w_rise[1]) w_evt_dir = 2'd1;
        else if (w_rise[2]) w_evt_dir = 2'd2;
        else                w_evt_dir = 2'd3;
        w_svc_valid = r_pend_valid | w_evt_valid;
        w_svc_dir   = r_pend_valid ? r_pend_dir : w_evt_dir;
        w_go        = (r_state == ST_IDLE) && w_svc_valid;
        w_ncol      = r_col;
        w_nrow      = r_row;
        w_blocked   = 1'b0;
        case (w_svc_dir)
            2'd0:    begin w_blocked = (r_row == 16'd0);         w_nrow = r_row - 16'd1; end
            2'd1:    begin w_blocked = (r_row == ROWS - 16'd1);  w_nrow = r_row + 16'd1; end
            2'd2:    begin w_blocked = (r_col == 16'd0);         w_ncol = r_col - 16'd1; end
            default: begin w_blocked = (r_col == COLS - 16'd1);  w_ncol = r_col + 16'd1; end
        endcase
        // In IDLE the first cell is the old one (MOVE erase) or the new one (DRAW trail)
        if (r_state == ST_IDLE) begin
            w_cell_col = r_mode ? w_ncol : r_col;
            w_cell_row = r_mode ? w_nrow : r_row;
        end else if (r_job == JOB_ERASE) begin
            w_cell_col = r_new_col;
            w_cell_row = r_new_row;
        end else begin
            w_cell_col = r_col;
            w_cell_row = r_row;
        end
        case (r_cidx)
            3'd0:    w_pal = 16'hFFFF;
            3'd1:    w_pal = 16'hF800;
            3'd2:    w_pal = 16'h07E0;
            3'd3:    w_pal = 16'h001F;
            3'd4:    w_pal = 16'hFFE0;
            3'd5:    w_pal = 16'hF81F;
            3'd6:    w_pal = 16'h07FF;
            default: w_pal = 16'hFD20;
        endcase
    end

    always_comb begin
        w_send = (r_state != ST_WAIT_INIT) && (r_state != ST_WAIT_SLP) && (r_state != ST_IDLE);
        w_byte_done = w_send && r_phase;
        w_last_byte = (r_state == ST_PIXEL) && w_byte_done && (r_cnt == r_nbytes - 32'd1);
        w_byte = 8'h00;
        w_dcx  = 1'b0;
        case (r_state)
            ST_SLPOUT:   w_byte = 8'h11;
            ST_COLMOD:   w_byte = 8'h3A;
            ST_COLMOD_D: begin w_byte = 8'h55; w_dcx = 1'b1; end
            ST_DISPON:   w_byte = 8'h29;
            ST_CASET:    w_byte = 8'h2A;
            ST_RASET:    w_byte = 8'h2B;
            ST_RAMWR:    w_byte = 8'h2C;
            ST_CASET_D, ST_RASET_D: begin
                w_dcx = 1'b1;
                case (r_cnt[1:0])
                    2'd0:    w_byte = (r_state == ST_CASET_D) ? r_xs[15:8] : r_ys[15:8];
                    2'd1:    w_byte = (r_state == ST_CASET_D) ? r_xs[7:0]  : r_ys[7:0];
                    2'd2:    w_byte = (r_state == ST_CASET_D) ? r_xe[15:8] : r_ye[15:8];
                    default: w_byte = (r_state == ST_CASET_D) ? r_xe[7:0]  : r_ye[7:0];
                endcase
            end
            ST_PIXEL: begin w_dcx = 1'b1; w_byte = r_cnt[0] ? r_color[7:0] : r_color[15:8]; end
            default: ;
        endcase
        w_next = r_state;
        case (r_state)
            ST_WAIT_INIT: if (r_cnt == 32'(INIT_WAIT - 1))  w_next = ST_SLPOUT;
            ST_SLPOUT:    if (w_byte_done)                  w_next = ST_WAIT_SLP;
            ST_WAIT_SLP:  if (r_cnt == 32'(SLEEP_WAIT - 1)) w_next = ST_COLMOD;
            ST_COLMOD:    if (w_byte_done)                  w_next = ST_COLMOD_D;
            ST_COLMOD_D:  if (w_byte_done)                  w_next = ST_DISPON;
            ST_DISPON:    if (w_byte_done)                  w_next = ST_CASET;
            ST_CASET:     if (w_byte_done)                  w_next = ST_CASET_D;
            ST_CASET_D:   if (w_byte_done && r_cnt == 32'd3) w_next = ST_RASET;
            ST_RASET:     if (w_byte_done)                  w_next = ST_RASET_D;
            ST_RASET_D:   if (w_byte_done && r_cnt == 32'd3) w_next = ST_RAMWR;
            ST_RAMWR:     if (w_byte_done)                  w_next = ST_PIXEL;
            ST_PIXEL:     if (w_last_byte) w_next = (r_job == JOB_DRAW) ? ST_IDLE : ST_CASET;
            ST_IDLE:      if (w_go && !w_blocked)           w_next = ST_CASET;
            default:                                        w_next = ST_WAIT_INIT;
        endcase
    end

    always_ff @(posedge hwclk) begin
        if (reset) r_state <= ST_WAIT_INIT;
        else       r_state <= w_next;
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_cnt <= '0; r_nbytes <= '0; r_phase <= 1'b0;
            r_wr <= 1'b1; r_dcx <= 1'b0; r_d <= 8'h00;
            r_col <= '0; r_row <= '0; r_new_col <= '0; r_new_row <= '0;
            r_xs <= '0; r_xe <= '0; r_ys <= '0; r_ye <= '0;
            r_job <= JOB_CLEAR; r_color <= BG_COLOR; r_mode <= 1'b0; r_cidx <= 3'd0;
            r_pend_valid <= 1'b0; r_pend_dir <= 2'd0;
        end else begin
            if (w_next != r_state)
                r_cnt <= '0;
            else if (!w_send || w_byte_done)
                r_cnt <= r_cnt + 32'd1;
            r_phase <= w_send && !r_phase;
            r_wr    <= !(w_send && !r_phase);
            if (w_send && !r_phase) begin
                r_dcx <= w_dcx;
                r_d   <= w_byte;
            end
            if (w_rise[4]) r_mode <= ~r_mode;
            if (w_rise[5]) r_cidx <= r_cidx + 3'd1;
            if (r_state == ST_IDLE)
                r_pend_valid <= 1'b0;
            else if (!r_pend_valid && w_evt_valid) begin
                r_pend_valid <= 1'b1;
                r_pend_dir   <= w_evt_dir;
            end
            if (r_state == ST_DISPON && w_byte_done) begin
                r_job <= JOB_CLEAR; r_color <= BG_COLOR; r_nbytes <= CLR_BYTES;
                r_xs <= 16'd0; r_xe <= 16'(H_RES - 1); r_ys <= 16'd0; r_ye <= 16'(V_RES - 1);
            end else if (w_last_byte && r_job != JOB_DRAW) begin
                r_job <= JOB_DRAW; r_color <= w_pal; r_nbytes <= CELL_BYTES;
                r_xs <= w_cell_col * CS; r_xe <= w_cell_col * CS + CS - 16'd1;
                r_ys <= w_cell_row * CS; r_ye <= w_cell_row * CS + CS - 16'd1;
                if (r_job == JOB_ERASE) begin
                    r_col <= r_new_col;
                    r_row <= r_new_row;
                end
            end else if (w_go && !w_blocked) begin
                r_nbytes <= CELL_BYTES;
                r_xs <= w_cell_col * CS; r_xe <= w_cell_col * CS + CS - 16'd1;
                r_ys <= w_cell_row * CS; r_ye <= w_cell_row * CS + CS - 16'd1;
                if (r_mode) begin
                    r_job <= JOB_DRAW; r_color <= w_pal; r_col <= w_ncol; r_row <= w_nrow;
                end else begin
                    r_job <= JOB_ERASE; r_color <= BG_COLOR; r_new_col <= w_ncol; r_new_row <= w_nrow;
                end
            end
        end
    end

    assign wr  = r_wr;
    assign dcx = r_dcx;
    assign D   = r_d;

`ifdef COMPLETE_SOUND_EN
    logic [31:0] r_beep_cnt, r_tone_cnt, r_half;
    logic        r_sq;
    // Every move decision (accepted or blocked) restarts the beep
    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_beep_cnt <= '0; r_tone_cnt <= '0; r_half <= '0; r_sq <= 1'b0;
        end else if (w_go) begin
            r_beep_cnt <= 32'(BEEP_LEN);
            r_tone_cnt <= '0;
            r_sq       <= 1'b1;
            r_half     <= w_blocked ? 32'(2 * TONE_DIV) : 32'(TONE_DIV);
        end else if (r_beep_cnt != 32'd0) begin
            r_beep_cnt <= r_beep_cnt - 32'd1;
            if (r_tone_cnt == r_half - 32'd1) begin
                r_tone_cnt <= '0;
                r_sq       <= ~r_sq;
            end else begin
                r_tone_cnt <= r_tone_cnt + 32'd1;
            end
        end
    end
    assign sound_out = (r_beep_cnt != 32'd0 && r_sq) ? 6'h3F : 6'h00;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{BEEP_LEN[0], TONE_DIV[0]};
    assign sound_out    = 6'h00;
`endif

endmodule

// File: tb/tb_complete_top.sv
// Scoreboard bench for complete_top on a shrunken 32x24 panel (4x3 cursor grid).
module tb_complete_top;
  localparam int INIT_WAIT  = 20;
  localparam int SLEEP_WAIT = 10;
  localparam int BEEP_LEN   = 200;
  localparam int TONE_DIV   = 5;
  localparam logic [5:0] B_UP = 6'h01, B_DOWN = 6'h02, B_LEFT = 6'h04, B_RIGHT = 6'h08;
  localparam logic [5:0] B_MODE = 6'h10, B_KEY = 6'h20;

  logic hwclk = 1'b0;
  logic reset = 1'b1;
  logic left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0, mode_pb = 1'b0, KeyEnc = 1'b0;
  logic dcx, wr;
  logic [7:0] D;
  logic [5:0] sound_out;

  logic [8:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int n_bytes = 0;

  always #5 hwclk = ~hwclk;

  complete_top #(
    .INIT_WAIT(INIT_WAIT), .SLEEP_WAIT(SLEEP_WAIT), .CUR_SIZE(8), .BG_COLOR(16'h0000),
    .BEEP_LEN(BEEP_LEN), .TONE_DIV(TONE_DIV), .H_RES(32), .V_RES(24)
  ) dut (
    .hwclk(hwclk), .reset(reset), .left(left), .right(right), .up(up), .down(down),
    .mode_pb(mode_pb), .KeyEnc(KeyEnc), .dcx(dcx), .wr(wr), .D(D), .sound_out(sound_out)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endtask

  // Monitor: each LCD byte shows wr=0 for exactly one cycle
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge hwclk);
      if (!reset && wr === 1'b0) begin
        n_bytes++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL lcd_byte unexpected got=%0h exp=none", {dcx, D});
        end else begin
          e = exp_q.pop_front();
          if ({dcx, D} === e) n_pass++;
          else $display("FAIL lcd_byte #%0d got=%0h exp=%0h", n_bytes, {dcx, D}, e);
        end
      end
    end
  end

  task automatic push_win(input int xs, input int xe, input int ys, input int ye);
    logic [15:0] a, b, c, d;
    a = 16'(xs); b = 16'(xe); c = 16'(ys); d = 16'(ye);
    exp_q.push_back(9'h02A);
    exp_q.push_back({1'b1, a[15:8]}); exp_q.push_back({1'b1, a[7:0]});
    exp_q.push_back({1'b1, b[15:8]}); exp_q.push_back({1'b1, b[7:0]});
    exp_q.push_back(9'h02B);
    exp_q.push_back({1'b1, c[15:8]}); exp_q.push_back({1'b1, c[7:0]});
    exp_q.push_back({1'b1, d[15:8]}); exp_q.push_back({1'b1, d[7:0]});
    exp_q.push_back(9'h02C);
  endtask

  task automatic push_pix(input int n, input logic [15:0] c);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b1, c[15:8]});
      exp_q.push_back({1'b1, c[7:0]});
    end
  endtask

  task automatic push_cell(input int col, input int row, input logic [15:0] c);
    push_win(col * 8, col * 8 + 7, row * 8, row * 8 + 7);
    push_pix(64, c);
  endtask

  task automatic push_init();
    exp_q.push_back(9'h011);
    exp_q.push_back(9'h03A);
    exp_q.push_back(9'h155);
    exp_q.push_back(9'h029);
    push_win(0, 31, 0, 23);
    push_pix(768, 16'h0000);
    push_cell(0, 0, 16'hFFFF);
  endtask

  task automatic press(input logic [5:0] m);
    @(negedge hwclk);
    {KeyEnc, mode_pb, right, left, down, up} = m;
    repeat (2) @(negedge hwclk);
    {KeyEnc, mode_pb, right, left, down, up} = 6'h00;
    repeat (2) @(negedge hwclk);
  endtask

  task automatic drain(input string nm);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 20000) begin
      @(negedge hwclk);
      b++;
    end
    check(nm, exp_q.size(), 0);
    repeat (20) @(negedge hwclk);
  endtask

  task automatic check_quiet(input string nm, input int cycles);
    int b0;
    b0 = n_bytes;
    repeat (cycles) @(negedge hwclk);
    check(nm, n_bytes - b0, 0);
  endtask

  task automatic check_tone(input string nm, input int half);
`ifdef COMPLETE_SOUND_EN
    int b, len;
    b = 0;
    while (sound_out == 6'h00 && b < 20) begin @(negedge hwclk); b++; end
    b = 0;
    while (sound_out != 6'h00 && b < 4 * half) begin @(negedge hwclk); b++; end
    len = 0;
    while (sound_out == 6'h00 && len < 4 * half) begin @(negedge hwclk); len++; end
    check(nm, len, half);
`else
    int nz;
    nz = 0;
    repeat (4 * half) begin
      @(negedge hwclk);
      if (sound_out != 6'h00) nz++;
    end
    check(nm, nz, 0);
`endif
  endtask

  initial begin
    int b;
    repeat (4) @(negedge hwclk);
    check("rst_wr", wr, 1);
    check("rst_dcx", dcx, 0);
    check("rst_d", D, 8'h00);
    check("rst_sound", sound_out, 0);

    // Init + clear; two right presses during clear: first pending, second dropped
    push_init();
    push_cell(0, 0, 16'h0000);
    push_cell(1, 0, 16'hFFFF);
    reset = 1'b0;
    repeat (INIT_WAIT - 2) @(negedge hwclk);
    check("idle_before_init", n_bytes, 0);
    check("idle_wr", wr, 1);
    b = 0;
    while (n_bytes < 100 && b < 2000) begin @(negedge hwclk); b++; end
    check("reach_clear", (n_bytes >= 100), 1);
    press(B_RIGHT);
    press(B_RIGHT);
    drain("init_clear_pending");

    // Accepted move: col 1 -> 2
    push_cell(1, 0, 16'h0000);
    push_cell(2, 0, 16'hFFFF);
    press(B_RIGHT);
    check_tone("tone_accept", TONE_DIV);
    drain("move_right");

    // Top border blocks up
    press(B_UP);
    check_tone("tone_blocked", 2 * TONE_DIV);
    check_quiet("blocked_up", 40);

    push_cell(2, 0, 16'h0000);
    push_cell(3, 0, 16'hFFFF);
    press(B_RIGHT);
    drain("move_to_col3");
    press(B_RIGHT);
    check_quiet("blocked_right", 40);

    // DRAW mode, colour F800: trail kept, only new cell drawn
    press(B_MODE);
    press(B_KEY);
    check_quiet("mode_key_quiet", 10);
    push_cell(3, 1, 16'hF800);
    press(B_DOWN);
    drain("draw_down_f800");

    push_cell(2, 1, 16'h07E0);
    press(B_KEY);
    press(B_LEFT);
    drain("draw_left_07e0");

    // Palette wraps back to FFFF; back to MOVE; up beats left
    repeat (6) press(B_KEY);
    press(B_MODE);
    push_cell(2, 1, 16'h0000);
    push_cell(2, 0, 16'hFFFF);
    press(B_UP | B_LEFT);
    drain("prio_up_over_left");

    push_cell(2, 0, 16'h0000);
    push_cell(2, 1, 16'hFFFF);
    press(B_DOWN | B_RIGHT);
    drain("prio_down_over_right");

    push_cell(2, 1, 16'h0000);
    push_cell(2, 2, 16'hFFFF);
    press(B_DOWN);
    drain("move_to_row2");
    press(B_DOWN);
    check_quiet("blocked_down", 40);

    // Reset in the middle of a DRAW-mode cell
    press(B_MODE);
    push_cell(1, 2, 16'hFFFF);
    b = n_bytes;
    press(B_LEFT);
    while (n_bytes < b + 20 && n_bytes - b < 1000) @(negedge hwclk);
    reset = 1'b1;
    @(posedge hwclk);
    #1;
    check("reset_abort_wr", wr, 1);
    exp_q.delete();
    repeat (3) @(negedge hwclk);
    check("reset2_dcx", dcx, 0);
    check("reset2_d", D, 8'h00);
    check("reset2_sound", sound_out, 0);
    push_init();
    reset = 1'b0;
    drain("reinit");

    // Mode and position were reset: MOVE from (0,0)
    push_cell(0, 0, 16'h0000);
    push_cell(1, 0, 16'hFFFF);
    press(B_RIGHT);
    drain("after_reset_move");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
